pc_fetch_controller: RTL and testbench

Sequences the program-counter register and the instruction-memory fetch handshake at the front of the three-stage pipeline. It decides each cycle whether the PC advances (`pc_enable`) and to what value (`pc_next`): sequential, branch/jump redirect, trap vector, or `mret` return. It also holds off fetch for a boot delay after reset, and remembers redirects that arrive while a fetch is outstanding so the stale instruction is dropped.

---
 rtl/pc_ctrl_pkg.sv | 27 ++
 rtl/pc_target_mux.sv | 42 ++++
 rtl/pc_fetch_controller.sv | 119 +++++++++++
 tb/tb_pc_fetch_controller.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC / instruction-fetch controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT,
    HOLD,
    FETCH
  } state_t;

  // Ordered so that a numerically larger value outranks a smaller one.
  typedef enum logic [1:0] {
    EV_NONE,
    EV_REDIRECT,
    EV_MRET,
    EV_TRAP
  } ev_prio_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
    ev_prio_t    prio;
  } pc_event_t;

endpackage

// File: rtl/pc_target_mux.sv
// Priority select of the control-flow target: current events versus the
// remembered pending event. Targets are word-aligned on the way out.
module pc_target_mux
  import pc_ctrl_pkg::*;
(
  input  logic        trap_valid,
  input  logic [31:0] trap_vector,
  input  logic        mret_valid,
  input  logic [31:0] mepc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  pc_event_t   pending,
  output logic        event_now,
  output pc_event_t   resolved
);

  pc_event_t current;

  // Rank this cycle's events: trap > mret > redirect.
  always_comb begin
    current = '0;
    if (trap_valid) begin
      current = '{valid: 1'b1, target: trap_vector & ALIGN_MASK, prio: EV_TRAP};
    end else if (mret_valid) begin
      current = '{valid: 1'b1, target: mepc & ALIGN_MASK, prio: EV_MRET};
    end else if (redirect_valid) begin
      current = '{valid: 1'b1, target: redirect_pc & ALIGN_MASK, prio: EV_REDIRECT};
    end
  end

  assign event_now = current.valid;

  // Current event wins over pending when its rank is equal or higher; this is
  // also exactly the rule for overwriting the pending register.
  always_comb begin
    resolved = pending;
    if (current.valid && (!pending.valid || current.prio >= pending.prio)) begin
      resolved = current;
    end
  end

endmodule

// File: rtl/pc_fetch_controller.sv
// PC sequencing and instruction-memory fetch handshake for the pipeline front.
module pc_fetch_controller
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_current,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_vector,
  input  logic        mret_valid,
  input  logic [31:0] mepc,
  input  logic        imem_ack,
  output logic        pc_enable,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic        fetch_valid,
  output logic        flush_fetch
);

  localparam logic [31:0] BOOT_LOAD = 32'(BOOT_CYCLES);

  state_t      state, state_next;
  logic [31:0] boot_count, boot_count_next;
  pc_event_t   pending, pending_next, resolved;
  logic        event_now;
  logic [31:0] pc_seq;

  assign pc_seq = pc_current + INSTR_BYTES;

  pc_target_mux u_target_mux (
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .mret_valid     (mret_valid),
    .mepc           (mepc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pending        (pending),
    .event_now      (event_now),
    .resolved       (resolved)
  );

  // State, boot counter and pending-event registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      boot_count <= BOOT_LOAD;
      pending    <= '0;
    end else begin
      state      <= state_next;
      boot_count <= boot_count_next;
      pending    <= pending_next;
    end
  end

  // Next-state and all outputs; outputs are forced idle while reset is high.
  always_comb begin
    state_next      = state;
    boot_count_next = boot_count;
    pending_next    = pending;
    pc_enable       = 1'b0;
    pc_next         = pc_seq;
    imem_req        = 1'b0;
    fetch_valid     = 1'b0;
    flush_fetch     = 1'b0;

    case (state)
      // Pending is always empty outside FETCH, so resolved is the current event.
      BOOT: begin
        if (boot_count != '0) boot_count_next = boot_count - 32'd1;
        // A load of 0 or 1 both give a single BOOT cycle.
        if (boot_count <= 32'd1) state_next = HOLD;
        if (event_now) begin
          pc_enable   = 1'b1;
          pc_next     = resolved.target;
          flush_fetch = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) state_next = FETCH;
        if (event_now) begin
          pc_enable   = 1'b1;
          pc_next     = resolved.target;
          flush_fetch = 1'b1;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          pending_next = '0;
          state_next   = stall ? HOLD : FETCH;
          pc_enable    = 1'b1;
          if (resolved.valid) begin
            pc_next     = resolved.target;
            flush_fetch = 1'b1;
          end else begin
            fetch_valid = 1'b1;
          end
        end else if (event_now) begin
          flush_fetch  = 1'b1;
          pending_next = resolved;
        end
      end
      default: state_next = BOOT;
    endcase

    if (reset) begin
      pc_enable   = 1'b0;
      imem_req    = 1'b0;
      fetch_valid = 1'b0;
      flush_fetch = 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Self-checking bench for pc_fetch_controller: directed scenarios followed by
// random traffic, all compared against a cycle-level reference model.
module tb_pc_fetch_controller;

  localparam int unsigned BOOT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_current = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        mret_valid = 1'b0;
  logic [31:0] mepc = '0;
  logic        imem_ack = 1'b0;
  logic        pc_enable;
  logic [31:0] pc_next;
  logic        imem_req;
  logic        fetch_valid;
  logic        flush_fetch;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  // Reference model: boot cycles left, whether fetching is active, and the
  // remembered event as (target, rank) with rank 3=trap 2=mret 1=redirect.
  int          m_boot_left;
  bit          m_fetch_on;
  bit          m_pend;
  logic [31:0] m_pend_tgt;
  int          m_pend_rank;

  bit          c_valid, r_valid;
  logic [31:0] r_tgt;
  int          r_rank;
  logic        e_en, e_req, e_fv, e_fl;
  logic [31:0] e_nxt;
  logic        s_en, s_req, s_fv, s_fl;
  logic [31:0] s_nxt, s_pc;

  pc_fetch_controller #(.BOOT_CYCLES(BOOT)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc_current     (pc_current),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .mret_valid     (mret_valid),
    .mepc           (mepc),
    .imem_ack       (imem_ack),
    .pc_enable      (pc_enable),
    .pc_next        (pc_next),
    .imem_req       (imem_req),
    .fetch_valid    (fetch_valid),
    .flush_fetch    (flush_fetch)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_boot_left = (BOOT == 0) ? 1 : int'(BOOT);
    m_fetch_on  = 1'b0;
    m_pend      = 1'b0;
    m_pend_tgt  = '0;
    m_pend_rank = 0;
  endfunction

  function automatic void model_expect();
    logic [31:0] ct;
    int          cr;
    ct = '0;
    cr = 0;
    if (trap_valid) begin
      cr = 3; ct = trap_vector;
    end else if (mret_valid) begin
      cr = 2; ct = mepc;
    end else if (redirect_valid) begin
      cr = 1; ct = redirect_pc;
    end
    ct = {ct[31:2], 2'b00};
    c_valid = (cr != 0);
    if (c_valid && (!m_pend || cr >= m_pend_rank)) begin
      r_valid = 1'b1; r_tgt = ct; r_rank = cr;
    end else begin
      r_valid = m_pend; r_tgt = m_pend_tgt; r_rank = m_pend_rank;
    end
    e_en = 1'b0; e_req = 1'b0; e_fv = 1'b0; e_fl = 1'b0;
    e_nxt = pc_current + 32'd4;
    if (m_boot_left > 0 || !m_fetch_on) begin
      if (c_valid) begin
        e_en = 1'b1; e_nxt = r_tgt; e_fl = 1'b1;
      end
    end else begin
      e_req = 1'b1;
      if (!imem_ack) begin
        e_fl = c_valid;
      end else if (r_valid) begin
        e_en = 1'b1; e_nxt = r_tgt; e_fl = 1'b1;
      end else begin
        e_en = 1'b1; e_fv = 1'b1;
      end
    end
  endfunction

  function automatic void model_advance();
    if (m_boot_left > 0) begin
      m_boot_left--;
    end else if (!m_fetch_on) begin
      if (!stall) m_fetch_on = 1'b1;
    end else if (imem_ack) begin
      m_pend = 1'b0;
      m_pend_rank = 0;
      if (stall) m_fetch_on = 1'b0;
    end else if (c_valid) begin
      m_pend = 1'b1; m_pend_tgt = r_tgt; m_pend_rank = r_rank;
    end
  endfunction

  // Called at posedge+1: check at the falling edge, then advance model and PC.
  task automatic tick();
    #4;
    model_expect();
    s_en = pc_enable; s_req = imem_req; s_fv = fetch_valid;
    s_fl = flush_fetch; s_nxt = pc_next; s_pc = pc_current;
    chk("pc_enable", pc_enable, e_en);
    chk("imem_req", imem_req, e_req);
    chk("fetch_valid", fetch_valid, e_fv);
    chk("flush_fetch", flush_fetch, e_fl);
    chk("pc_next", pc_next, e_nxt);
    @(posedge clock);
    #1;
    model_advance();
    if (e_en) pc_current = e_nxt;
  endtask

  task automatic clear_events();
    redirect_valid = 1'b0;
    trap_valid     = 1'b0;
    mret_valid     = 1'b0;
  endtask

  task automatic check_reset_idle(input string tag);
    chk({tag, "_en"}, pc_enable, 1'b0);
    chk({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_fv"}, fetch_valid, 1'b0);
    chk({tag, "_fl"}, flush_fetch, 1'b0);
  endtask

  initial begin
    // Reset with events active: outputs must stay idle.
    trap_valid = 1'b1; trap_vector = 32'h40; redirect_valid = 1'b1;
    repeat (2) @(posedge clock);
    #5;
    check_reset_idle("reset");
    clear_events();
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();

    // Boot delay then back-to-back fetches.
    imem_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k < 5) begin
        chk("boot_idle", s_req, 1'b0);
      end else begin
        chk("boot_fetch", s_req, 1'b1);
        chk("seq_pc", s_pc, 32'(4 * (k - 5)));
        chk("seq_valid", s_fv, 1'b1);
      end
    end

    // Stall during an ack: last delivery, then hold until stall drops.
    stall = 1'b1;
    tick();
    chk("stall_last_fv", s_fv, 1'b1);
    tick();
    chk("stall_hold_req", s_req, 1'b0);
    chk("stall_hold_en", s_en, 1'b0);
    stall = 1'b0;
    tick();
    chk("stall_release_req", s_req, 1'b0);
    tick();
    chk("stall_resume_req", s_req, 1'b1);
    chk("stall_resume_pc", s_pc, 32'd16);

    // Redirect while a fetch is outstanding.
    imem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    chk("redir_flush", s_fl, 1'b1);
    chk("redir_no_en", s_en, 1'b0);
    clear_events();
    tick();
    tick();
    imem_ack = 1'b1;
    tick();
    chk("redir_ack_fv", s_fv, 1'b0);
    chk("redir_ack_fl", s_fl, 1'b1);
    chk("redir_ack_nxt", s_nxt, 32'h100);

    // Pending overwrite by a higher-ranked event, and the reverse order.
    imem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    clear_events();
    trap_valid = 1'b1; trap_vector = 32'h80;
    tick();
    clear_events();
    imem_ack = 1'b1;
    tick();
    chk("prio_up_nxt", s_nxt, 32'h80);
    imem_ack = 1'b0;
    trap_valid = 1'b1;
    tick();
    clear_events();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    clear_events();
    imem_ack = 1'b1;
    tick();
    chk("prio_keep_nxt", s_nxt, 32'h80);

    // Simultaneous events in HOLD with an unaligned trap vector.
    stall = 1'b1;
    tick();
    trap_valid = 1'b1; mret_valid = 1'b1; redirect_valid = 1'b1;
    trap_vector = 32'h203; mepc = 32'h44; redirect_pc = 32'h300;
    tick();
    chk("simul_en", s_en, 1'b1);
    chk("simul_nxt", s_nxt, 32'h200);
    clear_events();
    stall = 1'b0;
    tick();

    // Sequential wrap, then asynchronous reset mid-fetch.
    pc_current = 32'hFFFF_FFFC;
    tick();
    chk("wrap_nxt", s_nxt, 32'h0);
    imem_ack = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    redirect_valid = 1'b1;
    #1;
    check_reset_idle("async_reset");
    clear_events();
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    imem_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("reboot_req", s_req, (k == 5) ? 1'b1 : 1'b0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      stall          = ($urandom_range(0, 9) < 3);
      imem_ack       = ($urandom_range(0, 1) == 1);
      redirect_valid = ($urandom_range(0, 6) == 0);
      trap_valid     = ($urandom_range(0, 9) == 0);
      mret_valid     = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom();
      trap_vector    = $urandom();
      mepc           = $urandom();
      if ($urandom_range(0, 39) == 0) pc_current = $urandom();
      if ($urandom_range(0, 79) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        check_reset_idle("rand_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, failed so far %0d", failed);
    $fatal(1, "timeout");
  end

endmodule
